// File: rtl/stream_window_3x3_if.sv
// Pixel-in / window-out handshake bundle for stream_window_3x3.
// STREAM_WINDOW_EOL_FLAGS_EN adds the out_eol/out_eof window tags.
interface stream_window_3x3_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0]   in_pixel;
   logic                in_valid;
   logic                in_sof;
   logic                in_ready;
   logic [9*DATA_W-1:0] out_window;
   logic                out_valid;
   logic                out_ready;
   logic                out_frame_done;
`ifdef STREAM_WINDOW_EOL_FLAGS_EN
   logic                out_eol;
   logic                out_eof;
`endif

   // master = pixel source / window sink, slave = the window generator
   modport master (
      output in_pixel, in_valid, in_sof, out_ready,
      input  in_ready, out_window, out_valid, out_frame_done
`ifdef STREAM_WINDOW_EOL_FLAGS_EN
      , input out_eol, out_eof
`endif
   );

   modport slave (
      input  in_pixel, in_valid, in_sof, out_ready,
      output in_ready, out_window, out_valid, out_frame_done
`ifdef STREAM_WINDOW_EOL_FLAGS_EN
      , output out_eol, out_eof
`endif
   );
endinterface

// File: rtl/stream_window_3x3.sv
// Raster-stream 3x3 window generator with two line buffers and one output register stage.
// Optional end-of-line/end-of-frame window tags under STREAM_WINDOW_EOL_FLAGS_EN.
module stream_window_3x3 #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 512,
   parameter int IMG_H  = 512
) (
   input  logic                 clk,
   input  logic                 reset,
   stream_window_3x3_if.slave   bus
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   if (IMG_W < 3 || IMG_H < 3) begin : g_bad_dims
      $error("stream_window_3x3: IMG_W and IMG_H must both be >= 3");
   end

   typedef logic [2:0][2:0][DATA_W-1:0] win_t;

   logic [DATA_W-1:0] lb1_q [IMG_W];
   logic [DATA_W-1:0] lb2_q [IMG_W];

   logic [CW-1:0] col_q, col_d, col_cur;
   logic [RW-1:0] row_q, row_d, row_cur;
   win_t          w_q, w_d, win_q;
   logic          out_valid_q, out_valid_d, done_q;
   logic          in_ready, acc, emit, last;

   always_comb begin
      in_ready = !out_valid_q || bus.out_ready;
      acc      = bus.in_valid && in_ready;
      // a start-of-frame pixel overrides the counters for this accept only
      col_cur  = bus.in_sof ? '0 : col_q;
      row_cur  = bus.in_sof ? '0 : row_q;
      emit     = acc && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
      last     = (col_cur == COL_LAST) && (row_cur == ROW_LAST);

      for (int i = 0; i < 3; i++) begin
         w_d[i][0] = w_q[i][1];
         w_d[i][1] = w_q[i][2];
      end
      w_d[0][2] = lb2_q[col_cur];
      w_d[1][2] = lb1_q[col_cur];
      w_d[2][2] = bus.in_pixel;

      col_d = col_cur + CW'(1);
      row_d = row_cur;
      if (col_cur == COL_LAST) begin
         col_d = '0;
         row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end

      out_valid_d = out_valid_q;
      if (emit)               out_valid_d = 1'b1;
      else if (bus.out_ready) out_valid_d = 1'b0;
   end

   // line buffers are never cleared: rows 0-1 refill them before any emission
   always_ff @(posedge clk) begin
      if (acc) begin
         lb2_q[col_cur] <= lb1_q[col_cur];
         lb1_q[col_cur] <= bus.in_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         w_q         <= '0;
         win_q       <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q      <= acc && last;
         out_valid_q <= out_valid_d;
         if (acc) begin
            col_q <= col_d;
            row_q <= row_d;
            w_q   <= w_d;
         end
         if (emit) win_q <= w_d;
      end
   end

`ifdef STREAM_WINDOW_EOL_FLAGS_EN
   logic eol_q, eof_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         eol_q <= 1'b0;
         eof_q <= 1'b0;
      end else if (emit) begin
         eol_q <= (col_cur == COL_LAST);
         eof_q <= last;
      end
   end

   assign bus.out_eol = eol_q;
   assign bus.out_eof = eof_q;
`endif

   assign bus.in_ready       = in_ready;
   assign bus.out_window     = win_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_frame_done = done_q;
endmodule

// File: tb/tb_stream_window_3x3.sv
// Directed + randomized bench for stream_window_3x3, checked against a frame-store model.
module tb_stream_window_3x3;
   localparam int DW = 8;
   localparam int IW = 8;
   localparam int IH = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   stream_window_3x3_if #(.DATA_W(DW)) bus ();

   stream_window_3x3 #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [9*DW-1:0] win;
      logic            eol;
      logic            eof;
   } exp_t;

   exp_t            exp_q[$];
   logic [9*DW-1:0] got_q[$];
   logic [9*DW-1:0] ref_q[$];
   logic [DW-1:0]   img [IH][IW];
   int              mr, mc;
   logic            done_exp;
   int              done_cnt, eol_cnt, eof_cnt;
   int              n_asserts, n_fail;
   int              rdy_mode;
   bit              gaps;
   logic [9*DW-1:0] first_win, last_win;

   task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int r, input int c);
      return DW'(r * 16 + c);
   endfunction

   // frame-store model: place each accepted pixel, emit the neighbourhood when interior
   task automatic model_accept(input logic [DW-1:0] pix, input logic sof);
      exp_t e;
      if (sof) begin
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               e.win[(i*3+j)*DW +: DW] = img[mr-2+i][mc-2+j];
         e.eol = (mc == IW - 1);
         e.eof = (mc == IW - 1) && (mr == IH - 1);
         exp_q.push_back(e);
      end
      done_exp = (mr == IH - 1) && (mc == IW - 1);
      mc++;
      if (mc == IW) begin
         mc = 0;
         mr = (mr == IH - 1) ? 0 : mr + 1;
      end
   endtask

   task automatic step(input logic iv, input logic [DW-1:0] pix, input logic sof, output logic accepted);
      logic ordy, pend;
      ordy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.in_valid  = iv;
      bus.in_pixel  = pix;
      bus.in_sof    = sof;
      bus.out_ready = ordy;
      #1;
      pend = (exp_q.size() != 0);
      chk("out_valid", bus.out_valid, pend);
      chk("in_ready", bus.in_ready, !pend || ordy);
      chk("frame_done", bus.out_frame_done, done_exp);
      if (bus.out_frame_done) done_cnt++;
      if (pend) begin
         chk("out_window", bus.out_window, exp_q[0].win);
`ifdef STREAM_WINDOW_EOL_FLAGS_EN
         chk("out_eol", bus.out_eol, exp_q[0].eol);
         chk("out_eof", bus.out_eof, exp_q[0].eof);
`endif
         if (ordy) begin
            got_q.push_back(bus.out_window);
`ifdef STREAM_WINDOW_EOL_FLAGS_EN
            if (bus.out_eol) eol_cnt++;
            if (bus.out_eof) eof_cnt++;
`endif
            void'(exp_q.pop_front());
         end
      end
      accepted = iv && (!pend || ordy);
      done_exp = 1'b0;
      if (accepted) model_accept(pix, sof);
      @(negedge clk);
   endtask

   task automatic send_pixel(input logic [DW-1:0] pix, input logic sof);
      logic a, iv;
      a = 1'b0;
      for (int t = 0; t < 200 && !a; t++) begin
         iv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         step(iv, pix, sof, a);
      end
      chk("send_accept", a, 1'b1);
   endtask

   task automatic send_range(input int n, input bit first_sof, input int stall_after);
      logic a;
      for (int k = 0; k < n; k++) begin
         send_pixel(pat(k / IW, k % IW), first_sof && (k == 0));
         if (k == stall_after) begin
            rdy_mode = 2;
            for (int s = 0; s < 5; s++)
               step(1'b1, pat((k + 1) / IW, (k + 1) % IW), 1'b0, a);
            rdy_mode = 0;
         end
      end
   endtask

   task automatic drain();
      logic a;
      for (int t = 0; t < 100 && (exp_q.size() != 0 || done_exp); t++)
         step(1'b0, '0, 1'b0, a);
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic reset_cycles(input int n);
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_pixel  = '0;
      bus.in_sof    = 1'b0;
      bus.out_ready = 1'b1;
      for (int t = 0; t < n; t++) begin
         @(negedge clk);
         #1;
         chk("rst_out_valid", bus.out_valid, 1'b0);
         chk("rst_frame_done", bus.out_frame_done, 1'b0);
         chk("rst_out_window", bus.out_window, '0);
      end
      reset = 1'b0;
      exp_q.delete();
      mr = 0;
      mc = 0;
      done_exp = 1'b0;
      @(negedge clk);
   endtask

   task automatic cmp_ref(input string tag);
      chk({tag, "_count"}, got_q.size(), ref_q.size());
      for (int k = 0; k < got_q.size() && k < ref_q.size(); k++)
         chk(tag, got_q[k], ref_q[k]);
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      rdy_mode  = 0;
      gaps      = 0;
      done_cnt  = 0;
      eol_cnt   = 0;
      eof_cnt   = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            first_win[(i*3+j)*DW +: DW] = pat(i, j);
            last_win[(i*3+j)*DW +: DW]  = pat(3 + i, 5 + j);
         end

      reset_cycles(3);

      // full frame, no gaps, always ready
      send_range(IW * IH, 1'b0, -1);
      drain();
      chk("t1_count", got_q.size(), 24);
      chk("t1_first", got_q[0], first_win);
      chk("t1_last", got_q[got_q.size()-1], last_win);
      chk("t1_done_pulses", done_cnt, 1);
`ifdef STREAM_WINDOW_EOL_FLAGS_EN
      chk("t1_eol_count", eol_cnt, 4);
      chk("t1_eof_count", eof_cnt, 1);
`endif
      ref_q = got_q;

      // five-cycle output stall right after window (2,4)
      got_q.delete();
      send_range(IW * IH, 1'b0, 2 * IW + 4);
      drain();
      cmp_ref("t2_seq");

      // random input gaps and random downstream ready
      got_q.delete();
      gaps = 1;
      rdy_mode = 1;
      send_range(IW * IH, 1'b0, -1);
      drain();
      cmp_ref("t3_seq");
      gaps = 0;
      rdy_mode = 0;

      // mid-frame resync after 20 pixels
      send_range(20, 1'b0, -1);
      drain();
      got_q.delete();
      send_range(IW * IH, 1'b1, -1);
      drain();
      chk("t4_first", got_q[0], first_win);
      cmp_ref("t4_seq");

      // reset after 30 pixels, then a clean frame without sof
      send_range(30, 1'b0, -1);
      reset_cycles(3);
      got_q.delete();
      send_range(IW * IH, 1'b0, -1);
      drain();
      cmp_ref("t5_seq");

      // random pixel data with gaps and backpressure
      gaps = 1;
      rdy_mode = 1;
      for (int k = 0; k < IW * IH; k++)
         send_pixel(DW'($urandom), 1'b0);
      drain();
      // second random frame with an sof on its first pixel
      for (int k = 0; k < IW * IH; k++)
         send_pixel(DW'($urandom), k == 0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
